// File: rtl/minmax_pkg.sv
// Shared state encoding and width-generic compare helper for the stream min/max tracker.
package minmax_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Operands are extended to this width by the caller, so the helper does not depend on WIDTH.
    localparam int CMP_W = 64;

    function automatic logic cmp_lt(input logic [CMP_W-1:0] a,
                                    input logic [CMP_W-1:0] b,
                                    input logic             sgn);
        if (sgn) return $signed(a) < $signed(b);
        return a < b;
    endfunction

endpackage

// File: rtl/minmax_cmp.sv
// Combinational signed/unsigned magnitude compare of two WIDTH-bit samples (WIDTH <= 64).
module minmax_cmp
    import minmax_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed_mode,
    output logic             o_lt,
    output logic             o_gt
);

    logic [CMP_W-1:0] w_a;
    logic [CMP_W-1:0] w_b;

    // Sign-extend only in signed mode so the wide compare matches a WIDTH-bit compare.
    generate
        if (WIDTH < CMP_W) begin : g_ext
            assign w_a = {{(CMP_W-WIDTH){i_signed_mode & i_a[WIDTH-1]}}, i_a};
            assign w_b = {{(CMP_W-WIDTH){i_signed_mode & i_b[WIDTH-1]}}, i_b};
        end else begin : g_full
            assign w_a = i_a;
            assign w_b = i_b;
        end
    endgenerate

    assign o_lt = cmp_lt(w_a, w_b, i_signed_mode);
    assign o_gt = cmp_lt(w_b, w_a, i_signed_mode);

endmodule

// File: rtl/stream_min_tracker.sv
// Per-frame running minimum (and index) over a valid/ready sample stream.
// Define MINTRACK_MAX_EN to also track the maximum and expose m_max / m_max_idx.
module stream_min_tracker
    import minmax_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    parameter  int SIGNED  = 0,
    localparam int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_min,
    output logic [IW-1:0]    m_idx,
    output logic [CW-1:0]    m_count
`ifdef MINTRACK_MAX_EN
    ,
    output logic [WIDTH-1:0] m_max,
    output logic [IW-1:0]    m_max_idx
`endif
);

    localparam logic SGN_MODE = (SIGNED != 0);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic [IW-1:0]    w_beat_idx;
    logic             w_accept;
    logic             w_first;
    logic             w_close;

    logic [WIDTH-1:0] r_acc_min;
    logic [IW-1:0]    r_acc_min_idx;
    logic             w_min_lt;
    logic             w_unused_min_gt;
    logic             w_min_take;
    logic [WIDTH-1:0] w_min_nxt;
    logic [IW-1:0]    w_min_idx_nxt;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_accept   = s_valid & s_ready;
    assign w_first    = (r_cnt == '0);
    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_beat_idx = r_cnt[IW-1:0];
    assign w_close    = w_accept & (s_last | (w_cnt_inc == CW'(MAX_LEN)));

    minmax_cmp #(.WIDTH(WIDTH)) u_min_cmp (
        .i_a           (s_data),
        .i_b           (r_acc_min),
        .i_signed_mode (SGN_MODE),
        .o_lt          (w_min_lt),
        .o_gt          (w_unused_min_gt)
    );

    // Strict compare keeps the earliest index on ties.
    assign w_min_take    = w_first | w_min_lt;
    assign w_min_nxt     = w_min_take ? s_data     : r_acc_min;
    assign w_min_idx_nxt = w_min_take ? w_beat_idx : r_acc_min_idx;

`ifdef MINTRACK_MAX_EN
    logic [WIDTH-1:0] r_acc_max;
    logic [IW-1:0]    r_acc_max_idx;
    logic             w_max_gt;
    logic             w_unused_max_lt;
    logic             w_max_take;
    logic [WIDTH-1:0] w_max_nxt;
    logic [IW-1:0]    w_max_idx_nxt;

    minmax_cmp #(.WIDTH(WIDTH)) u_max_cmp (
        .i_a           (s_data),
        .i_b           (r_acc_max),
        .i_signed_mode (SGN_MODE),
        .o_lt          (w_unused_max_lt),
        .o_gt          (w_max_gt)
    );

    assign w_max_take    = w_first | w_max_gt;
    assign w_max_nxt     = w_max_take ? s_data     : r_acc_max;
    assign w_max_idx_nxt = w_max_take ? w_beat_idx : r_acc_max_idx;
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_ACCUM;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                s_ready = 1'b1;
                if (w_close) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                m_valid = 1'b1;
                if (m_ready) w_state_nxt = ST_ACCUM;
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    // The beat counter clears at close; no beats are accepted while holding.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt         <= '0;
            r_acc_min     <= '0;
            r_acc_min_idx <= '0;
            m_min         <= '0;
            m_idx         <= '0;
            m_count       <= '0;
`ifdef MINTRACK_MAX_EN
            r_acc_max     <= '0;
            r_acc_max_idx <= '0;
            m_max         <= '0;
            m_max_idx     <= '0;
`endif
        end else if (w_accept) begin
            if (w_close) begin
                r_cnt     <= '0;
                m_min     <= w_min_nxt;
                m_idx     <= w_min_idx_nxt;
                m_count   <= w_cnt_inc;
`ifdef MINTRACK_MAX_EN
                m_max     <= w_max_nxt;
                m_max_idx <= w_max_idx_nxt;
`endif
            end else begin
                r_cnt         <= w_cnt_inc;
                r_acc_min     <= w_min_nxt;
                r_acc_min_idx <= w_min_idx_nxt;
`ifdef MINTRACK_MAX_EN
                r_acc_max     <= w_max_nxt;
                r_acc_max_idx <= w_max_idx_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_stream_min_tracker.sv
// Directed bench: an unsigned and a signed tracker share one input stream and are checked side by side.
module tb_stream_min_tracker;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       m_ready = 1'b1;
    logic [7:0] s_data  = 8'h00;

    logic       su_ready, mu_valid, ss_ready, ms_valid;
    logic [7:0] mu_min, ms_min;
    logic [3:0] mu_idx, ms_idx;
    logic [4:0] mu_count, ms_count;
`ifdef MINTRACK_MAX_EN
    logic [7:0] mu_max, ms_max;
    logic [3:0] mu_max_idx, ms_max_idx;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_min_tracker #(.WIDTH(8), .MAX_LEN(16), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(su_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(mu_valid), .m_ready(m_ready),
        .m_min(mu_min), .m_idx(mu_idx), .m_count(mu_count)
`ifdef MINTRACK_MAX_EN
        , .m_max(mu_max), .m_max_idx(mu_max_idx)
`endif
    );

    stream_min_tracker #(.WIDTH(8), .MAX_LEN(16), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(ss_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(ms_valid), .m_ready(m_ready),
        .m_min(ms_min), .m_idx(ms_idx), .m_count(ms_count)
`ifdef MINTRACK_MAX_EN
        , .m_max(ms_max), .m_max_idx(ms_max_idx)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        chk("s_ready_before_beat", 32'(su_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] umin, input logic [3:0] uidx,
                           input logic [7:0] smin, input logic [3:0] sidx, input logic [4:0] cnt);
        chk({tag, "_u_valid"}, 32'(mu_valid), 32'd1);
        chk({tag, "_s_valid"}, 32'(ms_valid), 32'd1);
        chk({tag, "_s_ready"}, 32'(su_ready), 32'd0);
        chk({tag, "_u_min"},   32'(mu_min),   32'(umin));
        chk({tag, "_u_idx"},   32'(mu_idx),   32'(uidx));
        chk({tag, "_s_min"},   32'(ms_min),   32'(smin));
        chk({tag, "_s_idx"},   32'(ms_idx),   32'(sidx));
        chk({tag, "_u_count"}, 32'(mu_count), 32'(cnt));
        chk({tag, "_s_count"}, 32'(ms_count), 32'(cnt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(su_ready), 32'd1);
        chk({tag, "_u_valid"}, 32'(mu_valid), 32'd0);
        chk({tag, "_s_valid"}, 32'(ms_valid), 32'd0);
        chk({tag, "_u_min"},   32'(mu_min),   32'd0);
        chk({tag, "_u_idx"},   32'(mu_idx),   32'd0);
        chk({tag, "_u_count"}, 32'(mu_count), 32'd0);
        chk({tag, "_s_min"},   32'(ms_min),   32'd0);
        chk({tag, "_s_count"}, 32'(ms_count), 32'd0);
    endtask

    initial begin
        logic [7:0] d;

        // Reset state
        tick(); tick(); tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick(); tick(); tick();

        // Basic unsigned frame; result appears one cycle after the last beat
        send(8'd9, 1'b0); send(8'd3, 1'b0); send(8'd7, 1'b0);
        chk("t1_no_early_valid", 32'(mu_valid), 32'd0);
        send(8'd3, 1'b1);
        chk_res("t1", 8'd3, 4'd1, 8'd3, 4'd1, 5'd4);
        tick();
        chk("t1_rearm_valid", 32'(mu_valid), 32'd0);
        chk("t1_rearm_ready", 32'(su_ready), 32'd1);
        chk("t1_min_held",    32'(mu_min),   32'd3);

        // Signed versus unsigned ordering of the same data
        send(8'h05, 1'b0); send(8'hFE, 1'b0); send(8'h80, 1'b0); send(8'h7F, 1'b1);
        chk_res("t2", 8'h05, 4'd0, 8'h80, 4'd2, 5'd4);
        tick();

        // MAX_LEN auto-close with a tie, then backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d = (i == 5 || i == 12) ? 8'd10 : 8'(200 - 3 * i);
            send(d, 1'b0);
            if (i == 14) chk("t3_no_early_close", 32'(mu_valid), 32'd0);
        end
        chk_res("t3", 8'h0A, 4'd5, 8'h9B, 4'd15, 5'd16);
        s_valid = 1'b1; s_data = 8'd1; s_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_bp_ready",  32'(su_ready), 32'd0);
            chk("t4_bp_valid",  32'(mu_valid), 32'd1);
            chk("t4_bp_min",    32'(mu_min),   32'h0A);
            chk("t4_bp_idx",    32'(mu_idx),   32'd5);
            chk("t4_bp_count",  32'(mu_count), 32'd16);
        end
        m_ready = 1'b1;
        tick();
        chk("t4_release_ready", 32'(su_ready), 32'd1);
        chk("t4_release_valid", 32'(mu_valid), 32'd0);
        chk("t4_release_min",   32'(mu_min),   32'h0A);
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        chk_res("t4", 8'd1, 4'd0, 8'd1, 4'd0, 5'd1);
        tick();

        // Min/max frame with a tie on the maximum
        send(8'd1, 1'b0); send(8'd8, 1'b0); send(8'd8, 1'b0); send(8'd0, 1'b1);
        chk_res("mm", 8'd0, 4'd3, 8'd0, 4'd3, 5'd4);
`ifdef MINTRACK_MAX_EN
        chk("mm_u_max",     32'(mu_max),     32'd8);
        chk("mm_u_max_idx", 32'(mu_max_idx), 32'd1);
        chk("mm_s_max",     32'(ms_max),     32'd8);
        chk("mm_s_max_idx", 32'(ms_max_idx), 32'd1);
`endif
        tick();

        // Idle cycles inside a frame leave the partial result untouched
        send(8'd6, 1'b0); tick();
        send(8'd2, 1'b0); tick(); tick();
        send(8'd4, 1'b1);
        chk_res("gap", 8'd2, 4'd1, 8'd2, 4'd1, 5'd3);
        tick();

        // Reset mid-frame discards the partial frame and the previous result
        send(8'd5, 1'b0); send(8'd1, 1'b0); send(8'd7, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero("t5_reset");
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        send(8'd4, 1'b0); send(8'd2, 1'b1);
        chk_res("t5", 8'd2, 4'd1, 8'd2, 4'd1, 5'd2);
        tick();
        chk("t5_rearm_valid", 32'(mu_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
